mips_cpu_bus_master: RTL and testbench
======================================

MIPS_CPU_BUS_MASTER -- requirements
Module: mips_cpu_bus_master

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum consecutive waitrequest-high cycles tolerated per bus transfer before timeout.
REQ-002 One clock; reset is asynchronous and active-high: ports clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  CPU-side request present.
REQ-006 req_write  input  1  1 = store, 0 = load/fetch.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 req_signed  input  1  sign-extend byte/half loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 req_ready  output  1  high only in IDLE; request accepted when req_valid and req_ready are high at a rising edge.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_err  output  1  qualifies resp_valid: misaligned, illegal size or timeout.
REQ-014 resp_rdata  output  32  extracted load data, valid with resp_valid.
REQ-015 address, read, write, byteenable[3:0], writedata[31:0]  outputs; waitrequest, readdata[31:0]  inputs: Avalon-style bus to memory.

Function
REQ-016 States: IDLE, XFER, RDATA, RESP.
REQ-017 IDLE: on acceptance, if the request is legal go to XFER; otherwise go to RESP with resp_err=1 and no bus activity.
REQ-018 Legality: size 11 illegal; word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
REQ-019 Accepted request fields are registered; CPU inputs are ignored until the next IDLE.
REQ-020 address = {req_addr[31:2],2'b00}; bus addresses are always word-aligned.
REQ-021 byteenable: word 1111; half at offset 0 -> 0011, at offset 2 -> 1100; byte at offset n -> 1 << n.
REQ-022 writedata: store data shifted to its lanes (byte to lane n, half to lanes 1:0 or 3:2); unenabled lanes are driven 0.
REQ-023 XFER: read or write (exactly one) held high with stable address, byteenable and writedata until a rising edge sees waitrequest=0.
REQ-024 XFER, write accepted: deassert write and go to RESP with resp_err=0.
REQ-025 XFER, read accepted: deassert read and go to RDATA; memory returns readdata exactly one cycle after the accepting edge.
REQ-026 RDATA: capture readdata, extract the addressed lane(s), zero- or sign-extend per req_signed, and go to RESP; word loads ignore req_signed.
REQ-027 Little-endian: byte at offset n is readdata[8n+7:8n].
REQ-028 Wait counter: cleared on entry to XFER and incremented on each XFER cycle with waitrequest=1.
REQ-029 Timeout: when the wait counter reaches MAX_WAIT with waitrequest still 1, deassert read/write and go to RESP with resp_err=1.
REQ-030 RESP: resp_valid=1 for exactly one cycle, then go to IDLE; resp_rdata is 0 for stores and for errors.
REQ-031 Minimum latencies from the accepting edge to resp_valid high: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-032 read and write are never high in the same cycle and never high outside XFER.
REQ-033 Back-to-back operation: a new request is accepted in the IDLE cycle immediately following RESP.

Reset
REQ-034 While reset is high: state IDLE, read=0, write=0, byteenable=0, address=0, writedata=0, resp_valid=0, resp_err=0, resp_rdata=0, wait counter 0, req_ready=0.
REQ-035 Reset asserted mid-transfer aborts the transfer immediately (asynchronously) with no response pulse; req_ready=1 from the first edge after reset deasserts.

Verification
REQ-036 Word load at 0x0000_0010, waitrequest=0, readdata=0x8899AABB -> byteenable=1111, address=0x10, resp_rdata=0x8899AABB, resp_valid 3 cycles after acceptance.
REQ-037 Signed byte load at 0x13, readdata=0x80FF0000 -> byteenable=1000, resp_rdata=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-038 Half store of 0x1234 at 0x22 with waitrequest high for 4 cycles -> write held 5 cycles, address=0x20, byteenable=1100, writedata=0x12340000, resp_valid with resp_err=0.
REQ-039 Word load at 0x06 -> no read asserted, resp_valid with resp_err=1 one cycle after acceptance.
REQ-040 MAX_WAIT=4 with waitrequest held high -> read drops after 4 wait cycles, resp_err=1; reset pulsed during a second XFER -> read=0 immediately, no resp_valid.

Source files
------------

// File: rtl/mips_cpu_bus_master.sv
// CPU load/store port to Avalon-style memory bus bridge.
// Handles lane steering, load extension, alignment checks and wait timeout.
module mips_cpu_bus_master #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RDATA,
      RESP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic            wr_q;
   logic [1:0]      size_q;
   logic            sgn_q;
   logic [1:0]      off_q;
   logic [CW-1:0]   wait_cnt;

   logic            legal;
   logic [3:0]      be_c;
   logic [31:0]     shifted;
   logic [31:0]     wd_c;
   logic [31:0]     lane;
   logic [31:0]     ext;
   logic            timeout;

   always_comb begin
      legal = 1'b0;
      be_c  = 4'b0000;
      unique case (req_size)
         2'b00: begin
            legal = 1'b1;
            be_c  = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            legal = ~req_addr[0];
            be_c  = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            legal = (req_addr[1:0] == 2'b00);
            be_c  = 4'b1111;
         end
         default: begin
            legal = 1'b0;
            be_c  = 4'b0000;
         end
      endcase
   end

   // Unused lanes forced to zero so stale upper store bits never leak
   always_comb begin
      shifted = req_wdata << {req_addr[1:0], 3'b000};
      wd_c    = shifted & {{8{be_c[3]}}, {8{be_c[2]}},
                           {8{be_c[1]}}, {8{be_c[0]}}};
   end

   always_comb begin
      lane = readdata >> {off_q, 3'b000};
      unique case (size_q)
         2'b00:   ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
         2'b01:   ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
         default: ext = lane;
      endcase
   end

   assign timeout = waitrequest && (wait_cnt == CW'(MAX_WAIT - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid)
               state_d = legal ? XFER : RESP;
         end
         XFER: begin
            if (!waitrequest)
               state_d = wr_q ? RESP : RDATA;
            else if (timeout)
               state_d = RESP;
         end
         RDATA: state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE) & ~reset;
   assign resp_valid = (state_q == RESP);
   assign read       = (state_q == XFER) & ~wr_q;
   assign write      = (state_q == XFER) & wr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         size_q     <= 2'b00;
         sgn_q      <= 1'b0;
         off_q      <= 2'b00;
         wait_cnt   <= '0;
         address    <= '0;
         byteenable <= '0;
         writedata  <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  wr_q       <= req_write;
                  size_q     <= req_size;
                  sgn_q      <= req_signed;
                  off_q      <= req_addr[1:0];
                  wait_cnt   <= '0;
                  resp_err   <= ~legal;
                  resp_rdata <= '0;
                  if (legal) begin
                     address    <= {req_addr[31:2], 2'b00};
                     byteenable <= be_c;
                     writedata  <= wd_c;
                  end
               end
            end
            XFER: begin
               if (waitrequest) begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (timeout)
                     resp_err <= 1'b1;
               end
            end
            RDATA: resp_rdata <= ext;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed bench for mips_cpu_bus_master: scoreboard of responses,
// bus-side lane/latency checks, timeout and mid-transfer reset.
module tb_mips_cpu_bus_master;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_valid4;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        waitrequest;
   logic [31:0] readdata;

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata, address, writedata;
   logic        read, write;
   logic [3:0]  byteenable;

   logic        req_ready4, resp_valid4, resp_err4;
   logic [31:0] resp_rdata4, address4, writedata4;
   logic        read4, write4;
   logic [3:0]  byteenable4;

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          wait_cfg = 0;
   int          xfer_cyc = 0;
   logic [31:0] mem_word = '0;
   bit          sel = 1'b0;

   mips_cpu_bus_master dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_err(resp_err), .resp_rdata(resp_rdata),
      .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   mips_cpu_bus_master #(.MAX_WAIT(4)) dut4 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid4), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready4), .resp_valid(resp_valid4),
      .resp_err(resp_err4), .resp_rdata(resp_rdata4),
      .address(address4), .read(read4), .write(write4),
      .byteenable(byteenable4), .writedata(writedata4),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   wire        o_ready = sel ? req_ready4  : req_ready;
   wire        o_rv    = sel ? resp_valid4 : resp_valid;
   wire        o_err   = sel ? resp_err4   : resp_err;
   wire [31:0] o_rd    = sel ? resp_rdata4 : resp_rdata;
   wire [31:0] o_addr  = sel ? address4    : address;
   wire        o_read  = sel ? read4       : read;
   wire        o_write = sel ? write4      : write;
   wire [3:0]  o_be    = sel ? byteenable4 : byteenable;
   wire [31:0] o_wd    = sel ? writedata4  : writedata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: waitrequest for the first wait_cfg transfer cycles,
   // readdata valid only in the cycle after the accepting edge
   assign waitrequest = (xfer_cyc < wait_cfg);

   always @(posedge clk) begin
      if (read | write | read4 | write4)
         xfer_cyc <= xfer_cyc + 1;
      else
         xfer_cyc <= 0;
      if ((read | read4) && !waitrequest)
         readdata <= mem_word;
      else
         readdata <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic xact(input bit d4, input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rword,
                       input int waits, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic [31:0] e_wd,
                       input bit e_err, input logic [31:0] e_rd,
                       input int e_lat, input int e_bus,
                       input string tag);
      int   lat;
      int   bus;
      int   bad;
      exp_t e;
      sel      = d4;
      wait_cfg = waits;
      mem_word = rword;
      chk({tag, " ready"}, o_ready, 1);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      if (d4) req_valid4 = 1'b1;
      else    req_valid  = 1'b1;
      exp_q.push_back('{err: e_err, rd: e_rd});
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_valid4 = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      bus = 0;
      bad = 0;
      while (!o_rv && lat < 400) begin
         if (o_read | o_write) begin
            bus++;
            if (o_read & o_write) bad++;
            if (o_read !== !wr || o_addr !== e_addr || o_be !== e_be) bad++;
            if (wr && o_wd !== e_wd) bad++;
         end
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " bus_ok"}, bad, 0);
      chk({tag, " bus_cycles"}, bus, e_bus);
      chk({tag, " latency"}, lat, e_lat);
      if (o_rv) begin
         e = exp_q.pop_front();
         chk({tag, " err"}, o_err, e.err);
         chk({tag, " rdata"}, o_rd, e.rd);
         chk({tag, " rw_in_resp"}, o_read | o_write, 0);
      end else begin
         chk({tag, " resp_timeout"}, 0, 1);
         exp_q.delete();
      end
      @(posedge clk); #1;
      chk({tag, " pulse_end"}, o_rv, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_valid4 = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst read", read, 0);
      chk("rst write", write, 0);
      chk("rst be", byteenable, 0);
      chk("rst addr", address, 0);
      chk("rst wdata", writedata, 0);
      chk("rst rvalid", resp_valid, 0);
      chk("rst err", resp_err, 0);
      chk("rst rdata", resp_rdata, 0);
      chk("rst ready", req_ready, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst ready", req_ready, 1);

      xact(0, 0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0,
           32'h10, 4'b1111, 0, 0, 32'h8899AABB, 3, 1, "ld_word");
      xact(0, 0, 2'b00, 1, 32'h13, 0, 32'h80FF0000, 0,
           32'h10, 4'b1000, 0, 0, 32'hFFFFFF80, 3, 1, "ld_sbyte");
      xact(0, 0, 2'b00, 0, 32'h13, 0, 32'h80FF0000, 0,
           32'h10, 4'b1000, 0, 0, 32'h00000080, 3, 1, "ld_ubyte");
      xact(0, 1, 2'b01, 0, 32'h22, 32'hFFFF1234, 0, 4,
           32'h20, 4'b1100, 32'h12340000, 0, 0, 6, 5, "st_half");
      xact(0, 0, 2'b10, 0, 32'h06, 0, 32'h5555AAAA, 0,
           0, 0, 0, 1, 0, 1, 0, "ld_misal");
      xact(0, 1, 2'b11, 0, 32'h08, 32'h1, 0, 0,
           0, 0, 0, 1, 0, 1, 0, "bad_size");
      xact(0, 0, 2'b01, 1, 32'h21, 0, 32'h12345678, 0,
           0, 0, 0, 1, 0, 1, 0, "ld_half_odd");
      xact(0, 1, 2'b00, 0, 32'h11, 32'hAABBCCDD, 0, 0,
           32'h10, 4'b0010, 32'h0000DD00, 0, 0, 2, 1, "st_byte1");
      xact(0, 0, 2'b01, 1, 32'h02, 0, 32'h80017FFF, 0,
           32'h0, 4'b1100, 0, 0, 32'hFFFF8001, 3, 1, "ld_shalf_hi");
      xact(0, 0, 2'b01, 1, 32'h00, 0, 32'h80017FFF, 0,
           32'h0, 4'b0011, 0, 0, 32'h00007FFF, 3, 1, "ld_shalf_lo");
      xact(0, 0, 2'b01, 0, 32'h02, 0, 32'h80017FFF, 0,
           32'h0, 4'b1100, 0, 0, 32'h00008001, 3, 1, "ld_uhalf_hi");
      xact(0, 0, 2'b10, 1, 32'h80, 0, 32'h80000000, 2,
           32'h80, 4'b1111, 0, 0, 32'h80000000, 5, 3, "ld_word_sg");
      xact(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 1,
           32'h40, 4'b1111, 32'hCAFEF00D, 0, 0, 3, 2, "st_word");
      xact(0, 0, 2'b00, 0, 32'h1F2, 0, 32'h12AB3456, 2,
           32'h1F0, 4'b0100, 0, 0, 32'h000000AB, 5, 3, "ld_ubyte2");
      xact(0, 1, 2'b00, 1, 32'h07, 32'h000000FE, 0, 0,
           32'h04, 4'b1000, 32'hFE000000, 0, 0, 2, 1, "st_byte3");

      xact(1, 0, 2'b10, 0, 32'h44, 0, 32'h0, 1000,
           32'h44, 4'b1111, 0, 1, 0, 5, 4, "tmo_ld");
      xact(1, 1, 2'b00, 0, 32'h45, 32'h77, 0, 1000,
           32'h44, 4'b0010, 32'h00007700, 1, 0, 5, 4, "tmo_st");

      sel        = 1'b1;
      wait_cfg   = 1000;
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_addr   = 32'h100;
      req_valid4 = 1'b1;
      @(posedge clk); #1;
      req_valid4 = 1'b0;
      @(posedge clk); #1;
      chk("mid read_before", read4, 1);
      reset = 1'b1;
      #1;
      chk("mid read_async", read4, 0);
      chk("mid rvalid", resp_valid4, 0);
      chk("mid addr", address4, 0);
      chk("mid be", byteenable4, 0);
      chk("mid ready", req_ready4, 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (resp_valid4 | read4) seen = 1'b1;
      end
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk("mid no_pulse", seen, 0);
      chk("mid ready_after", req_ready4, 1);
      chk("mid rvalid_after", resp_valid4, 0);

      xact(1, 0, 2'b10, 0, 32'h0, 0, 32'h11223344, 0,
           32'h0, 4'b1111, 0, 0, 32'h11223344, 3, 1, "post_mid_ld");

      chk("sb empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
